// File: rtl/sha256_block_sequencer.sv
// Purpose: sequences padded 512-bit blocks into an external SHA-256 compression core, chaining H across the blocks of a message.
// Latency: a block is accepted at edge N and core_start pulses in the next cycle. dig_valid rises in the cycle after core_done on the last block.
// Backpressure: in_ready is high only in IDLE. A held digest (dig_ready=0) stalls the sequencer in OUTPUT, and a core timeout parks it in ERROR until err_clear.
module sha256_block_sequencer #(
    parameter int TIMEOUT = 128,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_block,
    input  logic             in_first,
    input  logic             in_last,
    output logic             core_start,
    output logic [511:0]     core_block,
    output logic [255:0]     core_hin,
    input  logic             core_done,
    input  logic [255:0]     core_hout,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [255:0]     dig_value,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clear
);

    // SHA-256 initial hash value, H0 in the top word
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // WAIT cycle counter only ever needs to reach TIMEOUT-1
    localparam int              WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_OUTPUT,
        S_ERROR
    } state_t;

    // Work item handed to the core: held from LAUNCH until the sequencer is idle again
    typedef struct packed {
        logic [511:0] blk;
        logic [255:0] hin;
        logic         last;
    } job_t;

    state_t           r_state;
    job_t             r_job;
    logic             r_open;
    logic [255:0]     r_h;
    logic [CNT_W-1:0] r_blk_cnt;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_in_ready;
    logic             r_core_start;
    logic             r_dig_valid;
    logic             r_busy;
    logic             r_err;

    logic             w_accept;
    logic             w_new_msg;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_inc;

    // A block is taken only in IDLE. It restarts chaining when flagged first or when no message is open.
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_new_msg = in_first || !r_open;
    assign w_timeout = (r_wait_cnt == WAIT_LAST);
    assign w_cnt_inc = r_blk_cnt + CNT_W'(1);

    assign in_ready    = r_in_ready;
    assign core_start  = r_core_start;
    assign core_block  = r_job.blk;
    assign core_hin    = r_job.hin;
    assign dig_valid   = r_dig_valid;
    assign dig_value   = r_h;
    assign blk_count   = r_blk_cnt;
    assign busy        = r_busy;
    assign err_timeout = r_err;

    // Sequencer FSM. Every output flag is set on the transition into the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_job.blk    <= '0;
            r_job.hin    <= IV;
            r_job.last   <= 1'b0;
            r_open       <= 1'b0;
            r_h          <= IV;
            r_blk_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_in_ready   <= 1'b1;
            r_core_start <= 1'b0;
            r_dig_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_job.blk    <= in_block;
                        r_job.hin    <= w_new_msg ? IV : r_h;
                        r_job.last   <= in_last;
                        if (w_new_msg) begin
                            r_blk_cnt <= '0;
                        end
                        r_open       <= 1'b1;
                        r_state      <= S_LAUNCH;
                        r_in_ready   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_core_start <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_state      <= S_WAIT;
                    r_core_start <= 1'b0;
                    r_wait_cnt   <= '0;
                end
                S_WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (core_done) begin
                        r_h       <= core_hout;
                        r_blk_cnt <= w_cnt_inc;
                        if (r_job.last) begin
                            r_state     <= S_OUTPUT;
                            r_dig_valid <= 1'b1;
                        end else begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                        r_open  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (dig_ready) begin
                        r_state     <= S_IDLE;
                        r_dig_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_open      <= 1'b0;
                        r_blk_cnt   <= '0;
                    end
                end
                S_ERROR: begin
                    if (err_clear) begin
                        r_state    <= S_IDLE;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_in_ready   <= 1'b1;
                    r_core_start <= 1'b0;
                    r_dig_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_err        <= 1'b0;
                    r_open       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: a transaction-level model plus a mock core (hout = hin ^ block[255:0]).
// One DUT uses the default TIMEOUT for the data-path scenarios. A second DUT uses TIMEOUT=8 for the timeout scenario.
// A compare process checks both DUTs against the model after every rising edge, and the directed steps pin literal values.
module tb_sha256_block_sequencer;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_first, in_last;
    logic [511:0] in_block;
    logic         core_done;
    logic [255:0] core_hout;
    logic         dig_ready, err_clear;
    logic         in_ready, core_start, dig_valid, busy, err_timeout;
    logic [511:0] core_block;
    logic [255:0] core_hin, dig_value;
    logic [15:0]  blk_count;

    logic         in_valid2, err_clear2, core_done2;
    logic         in_ready2, core_start2, dig_valid2, busy2, err2;
    logic [511:0] core_block2;
    logic [255:0] core_hin2, dig_value2;
    logic [15:0]  blk_count2;

    sha256_block_sequencer #(.TIMEOUT(128), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_first(in_first), .in_last(in_last),
        .core_start(core_start), .core_block(core_block), .core_hin(core_hin),
        .core_done(core_done), .core_hout(core_hout), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .dig_value(dig_value), .blk_count(blk_count),
        .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    sha256_block_sequencer #(.TIMEOUT(8), .CNT_W(16)) u_dut_to (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_block(in_block), .in_first(in_first), .in_last(in_last),
        .core_start(core_start2), .core_block(core_block2), .core_hin(core_hin2),
        .core_done(core_done2), .core_hout(core_hout), .dig_valid(dig_valid2),
        .dig_ready(dig_ready), .dig_value(dig_value2), .blk_count(blk_count2),
        .busy(busy2), .err_timeout(err2), .err_clear(err_clear2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model state, updated by the stimulus tasks at the edges where transactions complete
    logic [255:0] m_h      = IV;
    logic [255:0] exp_hin  = IV;
    logic [511:0] exp_blk  = '0;
    logic         m_open   = 1'b0;
    logic         m_last   = 1'b0;
    logic [15:0]  m_cnt    = '0;
    logic         m_busy   = 1'b0;
    logic         m_dv     = 1'b0;
    logic         m_launch = 1'b0;
    logic [511:0] exp_blk2 = '0;
    logic         m_busy2  = 1'b0;
    logic         m_err2   = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        chk(name, 512'(act), 512'(exp));
    endtask

    task automatic check_reset(input string tag);
        chk_b({tag, "_in_ready"}, in_ready, 1'b1);
        chk_b({tag, "_core_start"}, core_start, 1'b0);
        chk_b({tag, "_dig_valid"}, dig_valid, 1'b0);
        chk({tag, "_dig_value"}, 512'(dig_value), 512'(IV));
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_err_timeout"}, err_timeout, 1'b0);
        chk({tag, "_blk_count"}, 512'(blk_count), 512'(16'd0));
        chk({tag, "_core_hin"}, 512'(core_hin), 512'(IV));
        chk({tag, "_core_block"}, core_block, 512'd0);
    endtask

    // Compare process: both DUTs against the model, 2 time units after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk_b("cmp_in_ready", in_ready, !m_busy);
            chk_b("cmp_busy", busy, m_busy);
            chk_b("cmp_core_start", core_start, m_launch);
            chk_b("cmp_dig_valid", dig_valid, m_dv);
            chk_b("cmp_err_timeout", err_timeout, 1'b0);
            chk("cmp_blk_count", 512'(blk_count), 512'(m_cnt));
            if (busy) begin
                chk("cmp_core_block", core_block, exp_blk);
                chk("cmp_core_hin", 512'(core_hin), 512'(exp_hin));
            end
            if (dig_valid) chk("cmp_dig_value", 512'(dig_value), 512'(m_h));
            chk_b("cmp2_in_ready", in_ready2, !m_busy2);
            chk_b("cmp2_busy", busy2, m_busy2);
            chk_b("cmp2_err", err2, m_err2);
            chk_b("cmp2_dig_valid", dig_valid2, 1'b0);
            chk("cmp2_blk_count", 512'(blk_count2), 512'(16'd0));
            chk("cmp2_dig_value", 512'(dig_value2), 512'(IV));
            if (busy2) begin
                chk("cmp2_core_block", core_block2, exp_blk2);
                chk("cmp2_core_hin", 512'(core_hin2), 512'(IV));
            end
        end
    end

    // n rising edges; the launch pulse lasts only the first of them
    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_launch = 1'b0;
        end
    endtask

    // Offer a block to the main DUT starting at a falling edge; returns at the falling edge inside LAUNCH
    task automatic send(input logic [511:0] blk, input logic first, input logic last);
        int k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk_b("send_in_ready", in_ready, 1'b1);
        in_block = blk;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        if (first || !m_open) begin
            exp_hin = IV;
            m_cnt   = '0;
        end else begin
            exp_hin = m_h;
        end
        exp_blk  = blk;
        m_last   = last;
        m_open   = 1'b1;
        m_busy   = 1'b1;
        m_launch = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_b("send_core_start", core_start, 1'b1);
    endtask

    // Mock core: core_done is sampled lat edges after the edge that ends LAUNCH
    task automatic core_complete(input int lat);
        wait_edges(lat);
        @(negedge clk);
        core_done = 1'b1;
        core_hout = core_hin ^ core_block[255:0];
        @(posedge clk);
        m_h   = exp_hin ^ exp_blk[255:0];
        m_cnt = m_cnt + 16'd1;
        if (m_last) m_dv = 1'b1;
        else m_busy = 1'b0;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    // Hold the digest for 'hold' cycles, then take it
    task automatic finish_digest(input int hold);
        repeat (hold) @(negedge clk);
        chk_b("hold_dig_valid", dig_valid, 1'b1);
        chk("hold_dig_value", 512'(dig_value), 512'(m_h));
        chk_b("hold_in_ready", in_ready, 1'b0);
        dig_ready = 1'b1;
        @(posedge clk);
        m_open = 1'b0;
        m_cnt  = '0;
        m_busy = 1'b0;
        m_dv   = 1'b0;
        @(negedge clk);
        dig_ready = 1'b0;
        chk_b("take_dig_valid", dig_valid, 1'b0);
        chk_b("take_in_ready", in_ready, 1'b1);
        chk("take_blk_count", 512'(blk_count), 512'(16'd0));
    endtask

    initial begin
        logic [511:0] blk;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        in_block   = '0;
        core_done  = 1'b0;
        core_hout  = '0;
        dig_ready  = 1'b0;
        err_clear  = 1'b0;
        in_valid2  = 1'b0;
        err_clear2 = 1'b0;
        core_done2 = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;
        @(negedge clk);

        // Single block, first=last=1, with the digest held back for 20 cycles
        blk = {256'hC0FFEE00_11223344_55667788_99AABBCC_DDEEFF00_12345678_9ABCDEF0_0F1E2D3C, 256'hFF};
        send(blk, 1'b1, 1'b1);
        chk("t1_core_hin", 512'(core_hin), 512'(IV));
        core_complete(66);
        chk_b("t1_dig_valid_after_done", dig_valid, 1'b1);
        chk("t1_dig_value", 512'(dig_value),
            512'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cde6));
        chk("t1_blk_count", 512'(blk_count), 512'(16'd1));
        finish_digest(20);

        // Two-block message: the second block must chain from the first result
        blk = {256'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A_01010101_02020202_03030303_04040404, 256'h1};
        send(blk, 1'b1, 1'b0);
        core_complete(66);
        chk_b("t2_in_ready_after_done", in_ready, 1'b1);
        chk_b("t2_no_digest_mid_msg", dig_valid, 1'b0);
        chk("t2_blk_count_mid", 512'(blk_count), 512'(16'd1));
        blk = {256'h0, 32'hFFFFFFFF, 224'h0};
        send(blk, 1'b0, 1'b1);
        chk("t2_core_hin_chained", 512'(core_hin),
            512'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd18));
        core_complete(66);
        chk("t2_dig_value", 512'(dig_value),
            512'(256'h95f61998_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd18));
        chk("t2_blk_count", 512'(blk_count), 512'(16'd2));
        finish_digest(2);

        // Restart: a first block while a message is open discards the chaining value
        blk = {256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000, 256'h1234};
        send(blk, 1'b1, 1'b0);
        core_complete(40);
        chk("t3_blk_count_open", 512'(blk_count), 512'(16'd1));
        blk = {256'h0BADF00D, 256'h2};
        send(blk, 1'b1, 1'b1);
        chk("t3_core_hin_iv", 512'(core_hin), 512'(IV));
        chk("t3_blk_count_cleared", 512'(blk_count), 512'(16'd0));
        core_complete(30);
        chk("t3_blk_count_end", 512'(blk_count), 512'(16'd1));
        chk("t3_dig_value", 512'(dig_value),
            512'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd1b));
        finish_digest(1);

        // Timeout on the TIMEOUT=8 instance, whose core never answers
        blk = {256'h13579BDF, 256'h2468ACE0};
        in_block  = blk;
        in_first  = 1'b1;
        in_last   = 1'b1;
        in_valid2 = 1'b1;
        @(posedge clk);
        exp_blk2 = blk;
        m_busy2  = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk_b("t4_core_start", core_start2, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_b("t4_no_err_in_8th_wait", err2, 1'b0);
        @(posedge clk);
        m_err2 = 1'b1;
        @(negedge clk);
        chk_b("t4_err_timeout", err2, 1'b1);
        chk_b("t4_in_ready_err", in_ready2, 1'b0);
        in_valid2 = 1'b1;
        repeat (3) @(negedge clk);
        in_valid2 = 1'b0;
        chk_b("t4_err_ignores_valid", err2, 1'b1);
        err_clear2 = 1'b1;
        @(posedge clk);
        m_err2  = 1'b0;
        m_busy2 = 1'b0;
        @(negedge clk);
        err_clear2 = 1'b0;
        chk_b("t4_clear_in_ready", in_ready2, 1'b1);
        chk_b("t4_clear_err", err2, 1'b0);

        // Reset 10 cycles after core_start, then a stale core_done
        blk = {256'hFEEDFACE, 256'hCAFEBABE};
        send(blk, 1'b1, 1'b1);
        wait_edges(10);
        @(negedge clk);
        reset  = 1'b1;
        m_h    = IV;
        m_open = 1'b0;
        m_cnt  = '0;
        m_busy = 1'b0;
        m_dv   = 1'b0;
        #1;
        check_reset("midwait");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        core_done = 1'b1;
        core_hout = 256'hDEAD_0000_BEEF;
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_b("t5_no_dig_valid", dig_valid, 1'b0);
            chk_b("t5_idle", busy, 1'b0);
            chk("t5_blk_count", 512'(blk_count), 512'(16'd0));
            chk("t5_dig_value", 512'(dig_value), 512'(IV));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
